// File: rtl/iq_upmixer.sv
// iq_upmixer: mixes held baseband I/Q onto an NCO carrier, one real sample per clock.
// Pipeline: acc -> ROM -> sign/mirror -> multiply -> subtract -> round/saturate.
module iq_upmixer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 14,
  parameter int LUT_ADDR  = 10,
  parameter int RATE      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 phase_inc,
  input  logic                        phase_reset,
  input  logic signed [IN_WIDTH-1:0]  in_i,
  input  logic signed [IN_WIDTH-1:0]  in_q,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        flag_clr,
  output logic                        sat_flag,
  output logic                        underrun_flag
);
  localparam int N     = 1 << LUT_ADDR;
  localparam int AW    = LUT_ADDR + 1;
  localparam int CW    = $clog2(RATE);
  localparam int PW    = IN_WIDTH + 18;
  localparam int SW    = IN_WIDTH + 19;
  localparam int SHIFT = IN_WIDTH + 17 - OUT_WIDTH;
  localparam int RW    = OUT_WIDTH + 3;
  localparam logic signed [RW-1:0] MAXV = RW'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  function automatic int tval(input int k);
    return $rtoi(131071.0 * $sin(3.141592653589793 * k / (2.0 * N)) + 0.5);
  endfunction

  logic [16:0] rom [N+1];
  for (genvar k = 0; k <= N; k++) begin : g_rom
    assign rom[k] = 17'(tval(k));
  end

  logic [CW-1:0]               cnt;
  logic [31:0]                 acc;
  logic signed [IN_WIDTH-1:0]  hold_i, hold_q;
  logic [16:0]                 ta, tb;
  logic [1:0]                  quad;
  logic signed [17:0]          cos_r, sin_r;
  logic signed [PW-1:0]        p_i, p_q;
  logic signed [SW-1:0]        sum;
  logic [5:0]                  vld;
  logic                        strobe;
  logic [LUT_ADDR-1:0]         a;
  logic [AW-1:0]               ia, ib;
  logic signed [17:0]          sel_s, sel_c, sin_n, cos_n;
  logic signed [SW-1:0]        sh;
  logic signed [RW-1:0]        rnd;
  logic                        sat_hi, sat_lo;

  assign strobe    = cnt == CW'(RATE - 1);
  assign in_ready  = strobe;
  assign out_valid = vld[5];

  always_comb begin
    a      = acc[29:30-LUT_ADDR];
    ia     = {1'b0, a};
    ib     = AW'(N) - ia;
    sel_s  = quad[0] ? $signed({1'b0, tb}) : $signed({1'b0, ta});
    sel_c  = quad[0] ? $signed({1'b0, ta}) : $signed({1'b0, tb});
    sin_n  = quad[1] ? -sel_s : sel_s;
    cos_n  = (quad[1] ^ quad[0]) ? -sel_c : sel_c;
    sh     = sum >>> SHIFT;
    rnd    = sh[RW-1:0] + RW'(sum[SHIFT-1]);
    sat_hi = rnd > MAXV;
    sat_lo = rnd < MINV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      acc           <= '0;
      hold_i        <= '0;
      hold_q        <= '0;
      ta            <= '0;
      tb            <= '0;
      quad          <= '0;
      cos_r         <= '0;
      sin_r         <= '0;
      p_i           <= '0;
      p_q           <= '0;
      sum           <= '0;
      out_data      <= '0;
      vld           <= '0;
      sat_flag      <= 1'b0;
      underrun_flag <= 1'b0;
    end else begin
      cnt           <= strobe ? '0 : cnt + 1'b1;
      acc           <= phase_reset ? '0 : acc + phase_inc;
      hold_i        <= strobe ? (in_valid ? in_i : '0) : hold_i;
      hold_q        <= strobe ? (in_valid ? in_q : '0) : hold_q;
      ta            <= rom[ia];
      tb            <= rom[ib];
      quad          <= acc[31:30];
      cos_r         <= cos_n;
      sin_r         <= sin_n;
      p_i           <= PW'(hold_i) * PW'(cos_r);
      p_q           <= PW'(hold_q) * PW'(sin_r);
      sum           <= SW'(p_i) - SW'(p_q);
      out_data      <= sat_hi ? MAXV[OUT_WIDTH-1:0] : sat_lo ? MINV[OUT_WIDTH-1:0] : rnd[OUT_WIDTH-1:0];
      vld           <= {vld[4:0], 1'b1};
      // a coincident set beats the clear
      sat_flag      <= sat_hi | sat_lo | (sat_flag & ~flag_clr);
      underrun_flag <= (strobe & ~in_valid) | (underrun_flag & ~flag_clr);
    end
  end
endmodule
